// File: rtl/uart_phy_rx.sv
// UART receive PHY: 8N1 framing, LSB first, 16 ticks per bit.
// The line is synchronised first, then each bit is sampled at its middle.
// Good bytes raise nd_o for one cycle. A low stop bit raises frame_err_o for one cycle.
module uart_phy_rx (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_i,
  input  logic       rxd_i,
  output logic [7:0] data_o,
  output logic       nd_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  logic       rx_meta_q, rxs_q;
  logic [1:0] state_q, state_d;
  logic [3:0] tick_cnt_q, tick_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] data_q, data_d;
  logic       nd_q, nd_d;
  logic       fe_q, fe_d;
  logic       armed_q, armed_d;

  // Two-flop synchroniser. It resets to the idle (high) line level.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rxd_i;
      rxs_q     <= rx_meta_q;
    end
  end

  // Next-state logic for the frame FSM. Nothing advances without a tick.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    sh_d       = sh_q;
    data_d     = data_q;
    armed_d    = armed_q;
    nd_d       = 1'b0;
    fe_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Arming needs the line to be seen high. This way a held break yields only one frame.
        if (rxs_q) armed_d = 1'b1;
        if (tick_i && !rxs_q && armed_q) begin
          state_d    = StStart;
          tick_cnt_d = 4'd0;
          armed_d    = 1'b0;
        end
      end
      StStart: begin
        if (tick_i) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd7) begin
            tick_cnt_d = 4'd0;
            bit_cnt_d  = 3'd0;
            // A line that is high again at mid start bit is a glitch.
            state_d    = rxs_q ? StIdle : StData;
          end
        end
      end
      StData: begin
        if (tick_i) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            sh_d = {rxs_q, sh_q[7:1]};
            if (bit_cnt_q == 3'd7) begin
              state_d = StStop;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
      end
      StStop: begin
        if (tick_i) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            state_d = StIdle;
            if (rxs_q) begin
              data_d = sh_q;
              nd_d   = 1'b1;
            end else begin
              fe_d = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counters and registered output pulses.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= StIdle;
      tick_cnt_q <= 4'd0;
      bit_cnt_q  <= 3'd0;
      sh_q       <= 8'h00;
      data_q     <= 8'h00;
      nd_q       <= 1'b0;
      fe_q       <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sh_q       <= sh_d;
      data_q     <= data_d;
      nd_q       <= nd_d;
      fe_q       <= fe_d;
      armed_q    <= armed_d;
    end
  end

  assign data_o      = data_q;
  assign nd_o        = nd_q;
  assign frame_err_o = fe_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_phy_rx.sv
// Testbench for uart_phy_rx. It serialises frames onto rxd_i and compares the received bytes against a queue of expected bytes.
module tb_uart_phy_rx;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       tick_i = 1'b0;
  logic       rxd_i = 1'b1;
  logic [7:0] data_o;
  logic       nd_o, frame_err_o, busy_o;

  uart_phy_rx dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .tick_i     (tick_i),
    .rxd_i      (rxd_i),
    .data_o     (data_o),
    .nd_o       (nd_o),
    .frame_err_o(frame_err_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // The tick is high every other clock, so one bit lasts 16 ticks = 32 clocks.
  initial begin
    forever begin
      @(posedge clk_i);
      #1 tick_i = ~tick_i;
    end
  end

  int checks = 0;
  int errors = 0;

  // Observed pulses.
  logic [7:0] rx_q[$];
  int fe_cnt = 0, both_cnt = 0, long_cnt = 0, lat_viol = 0;
  logic nd_prev = 1'b0, fe_prev = 1'b0, tick_prev = 1'b0;

  // Reference model state.
  logic [7:0] exp_q[$];
  int         exp_fe = 0;
  logic [7:0] last_good = 8'h00;

  always @(negedge clk_i) begin
    if (rst_i) begin
      if (nd_o) rx_q.push_back(data_o);
      if (frame_err_o) fe_cnt <= fe_cnt + 1;
      if (nd_o && frame_err_o) both_cnt <= both_cnt + 1;
      if ((nd_o && nd_prev) || (frame_err_o && fe_prev)) long_cnt <= long_cnt + 1;
      // A pulse must follow the cycle in which a tick was seen.
      if ((nd_o || frame_err_o) && !tick_prev) lat_viol <= lat_viol + 1;
    end
    nd_prev   <= nd_o;
    fe_prev   <= frame_err_o;
    tick_prev <= tick_i;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_bits(input int n);
    repeat (n * 32) @(posedge clk_i);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit chk_busy);
    rxd_i = 1'b0;
    wait_bits(1);
    if (chk_busy) chk("busy_mid_frame", {31'd0, busy_o}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      rxd_i = b[i];
      wait_bits(1);
    end
    rxd_i = stop_bit;
    wait_bits(1);
    if (stop_bit) begin
      exp_q.push_back(b);
      last_good = b;
    end else begin
      exp_fe++;
    end
  endtask

  task automatic check_rx(input string tag);
    int n;
    chk({tag, "_count"}, rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_byte"}, {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
    chk({tag, "_fe"}, fe_cnt, exp_fe);
    chk({tag, "_data_o"}, {24'd0, data_o}, {24'd0, last_good});
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] v;

    // Reset state.
    repeat (5) @(posedge clk_i);
    #1;
    chk("rst_data", {24'd0, data_o}, 32'd0);
    chk("rst_nd", {31'd0, nd_o}, 32'd0);
    chk("rst_fe", {31'd0, frame_err_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    rst_i = 1'b1;
    wait_bits(2);

    // Single good frame.
    send_frame(8'hA5, 1'b1, 1'b1);
    repeat (4) @(posedge clk_i);
    #1;
    chk("a5_busy_after", {31'd0, busy_o}, 32'd0);
    check_rx("a5");
    wait_bits(1);

    // Back-to-back frames.
    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h00, 1'b1, 1'b0);
    wait_bits(1);
    check_rx("b2b");

    // Bad stop bit, then a break. Only one error pulse is expected.
    wait_bits(1);
    send_frame(8'h55, 1'b0, 1'b0);
    wait_bits(30);
    chk("break_busy", {31'd0, busy_o}, 32'd0);
    check_rx("break");
    rxd_i = 1'b1;
    wait_bits(2);
    send_frame(8'h81, 1'b1, 1'b0);
    wait_bits(1);
    check_rx("after_break");

    // A four-tick glitch must be rejected as a false start.
    rxd_i = 1'b0;
    repeat (8) @(posedge clk_i);
    #1 rxd_i = 1'b1;
    wait_bits(2);
    chk("glitch_busy", {31'd0, busy_o}, 32'd0);
    check_rx("glitch");
    send_frame(8'h12, 1'b1, 1'b0);
    wait_bits(1);
    check_rx("after_glitch");

    // Reset in the middle of bit 4 of 0x7E aborts the frame.
    v = 8'h7E;
    rxd_i = 1'b0;
    wait_bits(1);
    for (int i = 0; i < 4; i++) begin
      rxd_i = v[i];
      wait_bits(1);
    end
    rxd_i = v[4];
    repeat (16) @(posedge clk_i);
    #1 rst_i = 1'b0;
    last_good = 8'h00;
    repeat (3) @(posedge clk_i);
    #1;
    chk("midrst_busy", {31'd0, busy_o}, 32'd0);
    rxd_i = 1'b1;
    rst_i = 1'b1;
    wait_bits(2);
    check_rx("midrst");
    send_frame(8'hC3, 1'b1, 1'b0);
    wait_bits(1);
    check_rx("after_rst");

    // Randomised loopback with random idle gaps, including zero-length gaps.
    for (int f = 0; f < 120; f++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, 1'b0);
      wait_bits($urandom_range(0, 2));
    end
    wait_bits(1);
    check_rx("loopback");

    chk("nd_fe_exclusive", both_cnt, 32'd0);
    chk("pulse_width", long_cnt, 32'd0);
    chk("pulse_latency", lat_viol, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
